// File: rtl/layer1_bias_act_if.sv
`default_nettype none
// ============================================================================
// Module      : layer1_bias_act_if
// Description : Start/data/done bundle between layer-1 MAC array, bias loader,
//               the bias/activation stage and layer 2.
// Revision    : 1.0 - initial release
// ============================================================================
interface layer1_bias_act_if #(
    parameter int OUT_SIZE = 8,
    parameter int W        = 8,
    parameter int ACC_W    = 20
);
    logic                    start;
    logic [OUT_SIZE*ACC_W-1:0] acc_in;
    logic [OUT_SIZE*W-1:0]   bias_in;
    logic [OUT_SIZE*W-1:0]   data_out;
    logic                    done;

    modport master (
        output start,
        output acc_in,
        output bias_in,
        input  data_out,
        input  done
    );

    modport slave (
        input  start,
        input  acc_in,
        input  bias_in,
        output data_out,
        output done
    );
endinterface
`default_nettype wire

// File: rtl/layer1_bias_act.sv
`default_nettype none
// ============================================================================
// Module      : layer1_bias_act
// Description : Dense layer 1 bias add, requantise/saturate and optional ReLU,
//               one neuron per cycle. ReLU enabled by macro LAYER1_RELU_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module layer1_bias_act #(
    parameter int OUT_SIZE   = 8,
    parameter int W          = 8,
    parameter int ACC_W      = 20,
    parameter int BIAS_SHIFT = 4,
    parameter int OUT_SHIFT  = 4
) (
    input  logic              clk,
    input  logic              rst,
    layer1_bias_act_if.slave  bus
);

    localparam int c_IDX_W = $clog2(OUT_SIZE) + 1;
    localparam int c_SUM_W = ACC_W + BIAS_SHIFT + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PROC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [c_IDX_W-1:0]        c_LAST = c_IDX_W'(OUT_SIZE - 1);
    localparam logic signed [c_SUM_W-1:0] c_MAX  = c_SUM_W'((1 << (W - 1)) - 1);
    localparam logic signed [c_SUM_W-1:0] c_MIN  = ~c_MAX;

    logic [1:0]                r_state;
    logic [c_IDX_W-1:0]        r_idx;
    logic [OUT_SIZE*ACC_W-1:0] r_acc_q;
    logic [OUT_SIZE*W-1:0]     r_bias_q;
    logic [OUT_SIZE*W-1:0]     r_data_out;

    logic [ACC_W-1:0]          w_acc;
    logic [W-1:0]              w_bias;
    logic signed [c_SUM_W-1:0] w_a;
    logic signed [c_SUM_W-1:0] w_b;
    logic signed [c_SUM_W-1:0] w_s;
    logic signed [c_SUM_W-1:0] w_t;
    logic [W-1:0]              w_sat;
    logic [W-1:0]              w_act;

    always_comb begin
        w_acc  = '0;
        w_bias = '0;
        for (int i = 0; i < OUT_SIZE; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
                w_acc  = r_acc_q[i*ACC_W +: ACC_W];
                w_bias = r_bias_q[i*W +: W];
            end
        end
    end

    // Sum width leaves one spare bit, so the add cannot overflow.
    always_comb begin
        w_a = {{(c_SUM_W - ACC_W){w_acc[ACC_W-1]}}, w_acc};
        w_b = {{(c_SUM_W - W){w_bias[W-1]}}, w_bias} <<< BIAS_SHIFT;
        w_s = w_a + w_b;
        w_t = w_s >>> OUT_SHIFT;
        if (w_t > c_MAX) begin
            w_sat = {1'b0, {(W - 1){1'b1}}};
        end else if (w_t < c_MIN) begin
            w_sat = {1'b1, {(W - 1){1'b0}}};
        end else begin
            w_sat = w_t[W-1:0];
        end
`ifdef LAYER1_RELU_EN
        w_act = w_sat[W-1] ? '0 : w_sat;
`else
        w_act = w_sat;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_acc_q    <= '0;
            r_bias_q   <= '0;
            r_data_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_acc_q    <= bus.acc_in;
                        r_bias_q   <= bus.bias_in;
                        r_data_out <= '0;
                        r_idx      <= '0;
                        r_state    <= S_PROC;
                    end
                end
                S_PROC: begin
                    for (int i = 0; i < OUT_SIZE; i++) begin
                        if (r_idx == c_IDX_W'(i)) begin
                            r_data_out[i*W +: W] <= w_act;
                        end
                    end
                    r_idx <= r_idx + c_IDX_W'(1);
                    if (r_idx == c_LAST) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Start must drop before another pass can be accepted.
                    if (!bus.start) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.data_out = r_data_out;
    assign bus.done     = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_layer1_bias_act.sv
`default_nettype none
// ============================================================================
// Module      : tb_layer1_bias_act
// Description : Self-checking bench for layer1_bias_act with a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_layer1_bias_act;

    localparam int OUT_SIZE   = 8;
    localparam int W          = 8;
    localparam int ACC_W      = 20;
    localparam int BIAS_SHIFT = 4;
    localparam int OUT_SHIFT  = 4;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    int   acc_v  [OUT_SIZE];
    int   bias_v [OUT_SIZE];

    layer1_bias_act_if #(.OUT_SIZE(OUT_SIZE), .W(W), .ACC_W(ACC_W)) bus ();

    layer1_bias_act #(
        .OUT_SIZE  (OUT_SIZE),
        .W         (W),
        .ACC_W     (ACC_W),
        .BIAS_SHIFT(BIAS_SHIFT),
        .OUT_SHIFT (OUT_SHIFT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [W-1:0] model(input int a, input int b);
        longint s;
        longint hi;
        longint lo;
        s  = longint'(a) + longint'(b) * (longint'(1) << BIAS_SHIFT);
        s  = s >>> OUT_SHIFT;
        hi = (longint'(1) << (W - 1)) - 1;
        lo = -(longint'(1) << (W - 1));
        if (s > hi) s = hi;
        if (s < lo) s = lo;
`ifdef LAYER1_RELU_EN
        if (s < 0) s = 0;
`endif
        return W'(s);
    endfunction

    function automatic logic [W-1:0] out_word(input int i);
        return bus.data_out[i*W +: W];
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < OUT_SIZE; i++) begin
            bus.acc_in[i*ACC_W +: ACC_W] = ACC_W'(acc_v[i]);
            bus.bias_in[i*W +: W]        = W'(bias_v[i]);
        end
    endtask

    task automatic rand_inputs(input bit full);
        for (int i = 0; i < OUT_SIZE; i++) begin
            if (full) acc_v[i] = int'($urandom_range(0, (1 << ACC_W) - 1)) - (1 << (ACC_W - 1));
            else      acc_v[i] = int'($urandom_range(0, 6000)) - 3000;
            bias_v[i] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    // Raise start with the current inputs; count edges from the capture edge until done.
    task automatic run_pass(output int edges);
        @(negedge clk);
        drive_inputs();
        bus.start = 1'b1;
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (!bus.done && edges < 40);
    endtask

    task automatic end_pass();
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.acc_in = '0;
        bus.bias_in = '0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (bus.done !== 1'b0) begin
            n_fail++; $display("FAIL reset_done: got %b expected 0", bus.done);
        end
        n_cmp++;
        if (bus.data_out !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h expected 0", bus.data_out);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_nominal();
        int edges;
        for (int i = 0; i < OUT_SIZE; i++) begin acc_v[i] = 160; bias_v[i] = 2; end
        run_pass(edges);
        n_cmp++;
        if (edges !== 9) begin
            n_fail++; $display("FAIL nominal_latency: got %0d edges expected 9", edges);
        end
        for (int i = 0; i < OUT_SIZE; i++) begin
            n_cmp++;
            if (out_word(i) !== 8'h0C) begin
                n_fail++; $display("FAIL nominal_out[%0d]: got %h expected 0c", i, out_word(i));
            end
        end
        end_pass();
    endtask

    task automatic test_saturation();
        int edges;
        logic [W-1:0] exp_v [OUT_SIZE];
        for (int i = 0; i < OUT_SIZE; i++) begin acc_v[i] = 0; bias_v[i] = 0; exp_v[i] = 8'h00; end
        acc_v[3] = 4000;   exp_v[3] = 8'h7F;
        acc_v[0] = -64;    bias_v[0] = 1;
        acc_v[5] = -5000;
        acc_v[7] = -1;
`ifdef LAYER1_RELU_EN
        exp_v[0] = 8'h00; exp_v[5] = 8'h00; exp_v[7] = 8'h00;
`else
        exp_v[0] = 8'hFD; exp_v[5] = 8'h80; exp_v[7] = 8'hFF;
`endif
        run_pass(edges);
        n_cmp++;
        if (edges !== 9) begin
            n_fail++; $display("FAIL sat_latency: got %0d edges expected 9", edges);
        end
        for (int i = 0; i < OUT_SIZE; i++) begin
            n_cmp++;
            if (out_word(i) !== exp_v[i]) begin
                n_fail++; $display("FAIL sat_out[%0d]: got %h expected %h", i, out_word(i), exp_v[i]);
            end
        end
        end_pass();
    endtask

    task automatic test_independence();
        int edges;
        logic [W-1:0] exp_v [OUT_SIZE];
        rand_inputs(1'b0);
        for (int i = 0; i < OUT_SIZE; i++) exp_v[i] = model(acc_v[i], bias_v[i]);
        @(negedge clk);
        drive_inputs();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        edges = 1;
        rand_inputs(1'b1);
        drive_inputs();
        while (!bus.done && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        n_cmp++;
        if (edges !== 9) begin
            n_fail++; $display("FAIL indep_latency: got %0d edges expected 9", edges);
        end
        for (int i = 0; i < OUT_SIZE; i++) begin
            n_cmp++;
            if (out_word(i) !== exp_v[i]) begin
                n_fail++; $display("FAIL indep_out[%0d]: got %h expected %h", i, out_word(i), exp_v[i]);
            end
        end
        end_pass();
    endtask

    task automatic test_reset_mid();
        int edges;
        rand_inputs(1'b0);
        @(negedge clk);
        drive_inputs();
        bus.start = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.start = 1'b0;
        #1;
        n_cmp++;
        if (bus.data_out !== '0) begin
            n_fail++; $display("FAIL midrst_data: got %h expected 0", bus.data_out);
        end
        n_cmp++;
        if (bus.done !== 1'b0) begin
            n_fail++; $display("FAIL midrst_done: got %b expected 0", bus.done);
        end
        @(negedge clk);
        rst = 1'b0;
        rand_inputs(1'b0);
        run_pass(edges);
        n_cmp++;
        if (edges !== 9) begin
            n_fail++; $display("FAIL midrst_latency: got %0d edges expected 9", edges);
        end
        for (int i = 0; i < OUT_SIZE; i++) begin
            n_cmp++;
            if (out_word(i) !== model(acc_v[i], bias_v[i])) begin
                n_fail++; $display("FAIL midrst_out[%0d]: got %h expected %h", i, out_word(i), model(acc_v[i], bias_v[i]));
            end
        end
        end_pass();
    endtask

    task automatic test_start_hold();
        int edges;
        logic [OUT_SIZE*W-1:0] exp_vec;
        rand_inputs(1'b0);
        for (int i = 0; i < OUT_SIZE; i++) exp_vec[i*W +: W] = model(acc_v[i], bias_v[i]);
        run_pass(edges);
        rand_inputs(1'b1);
        drive_inputs();
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (bus.done !== 1'b1) begin
                n_fail++; $display("FAIL hold_done[%0d]: got %b expected 1", k, bus.done);
            end
            n_cmp++;
            if (bus.data_out !== exp_vec) begin
                n_fail++; $display("FAIL hold_data[%0d]: got %h expected %h", k, bus.data_out, exp_vec);
            end
        end
        end_pass();
        n_cmp++;
        if (bus.done !== 1'b0) begin
            n_fail++; $display("FAIL hold_release_done: got %b expected 0", bus.done);
        end
        rand_inputs(1'b0);
        run_pass(edges);
        n_cmp++;
        if (edges !== 9) begin
            n_fail++; $display("FAIL hold_restart_latency: got %0d edges expected 9", edges);
        end
        for (int i = 0; i < OUT_SIZE; i++) begin
            n_cmp++;
            if (out_word(i) !== model(acc_v[i], bias_v[i])) begin
                n_fail++; $display("FAIL hold_restart_out[%0d]: got %h expected %h", i, out_word(i), model(acc_v[i], bias_v[i]));
            end
        end
        end_pass();
    endtask

    task automatic test_random();
        int edges;
        for (int p = 0; p < 24; p++) begin
            rand_inputs(p[0]);
            run_pass(edges);
            n_cmp++;
            if (edges !== 9) begin
                n_fail++; $display("FAIL rand_latency[%0d]: got %0d edges expected 9", p, edges);
            end
            for (int i = 0; i < OUT_SIZE; i++) begin
                n_cmp++;
                if (out_word(i) !== model(acc_v[i], bias_v[i])) begin
                    n_fail++;
                    $display("FAIL rand_out[%0d][%0d]: acc=%0d bias=%0d got %h expected %h",
                             p, i, acc_v[i], bias_v[i], out_word(i), model(acc_v[i], bias_v[i]));
                end
            end
            end_pass();
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_nominal();
        test_saturation();
        test_independence();
        test_reset_mid();
        test_start_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
